// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one request at a time
// and buffers responses in an in-order queue feeding decode.
module ysyx_25030085_ifu #(
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = 32'h8000_0000,
   parameter int            DEPTH    = 4
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req_valid,
   input  logic          imem_req_ready,
   output logic [AW-1:0] imem_req_addr,
   input  logic          imem_rsp_valid,
   input  logic [31:0]   imem_rsp_data,
   input  logic          imem_rsp_err,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [31:0]   inst_data,
   output logic [AW-1:0] inst_pc,
   output logic          inst_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   fetch_pc;
   logic [CW-1:0]   count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   logic [31:0]     q_data [DEPTH];
   logic [AW-1:0]   q_pc   [DEPTH];
   logic            q_err  [DEPTH];

   logic            hs;
   logic            push;
   logic            pop;
   logic            unused_pc_lsb;

   assign unused_pc_lsb = ^redirect_pc[1:0];

   assign imem_req_valid = !rst && (state == S_REQ)
                         && (count < CW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign inst_valid     = !rst && (count != '0);
   assign inst_data      = q_data[rd_ptr];
   assign inst_pc        = q_pc[rd_ptr];
   assign inst_err       = q_err[rd_ptr];

   assign hs   = imem_req_valid && imem_req_ready;
   // A redirect kills both the arriving response and any pop.
   assign push = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
   assign pop  = inst_valid && inst_ready && !redirect_valid;

   // Next-state logic; a redirect turns any in-flight request stale.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_REQ: begin
            if (hs) begin
               state_nx = redirect_valid ? S_DISCARD : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               state_nx = S_REQ;
            end else if (redirect_valid) begin
               state_nx = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem_rsp_valid) begin
               state_nx = S_REQ;
            end
         end
         default: state_nx = S_REQ;
      endcase
   end

   // State, fetch PC and queue bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_REQ;
         fetch_pc <= {RESET_PC[AW-1:2], 2'b00};
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state <= state_nx;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[AW-1:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + AW'(4);
               wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
               count <= count + CW'(1);
            end else if (pop && !push) begin
               count <= count - CW'(1);
            end
         end
      end
   end

   // Queue storage: written at the tail on every accepted response.
   always_ff @(posedge clk) begin
      if (push) begin
         q_data[wr_ptr] <= imem_rsp_data;
         q_pc[wr_ptr]   <= fetch_pc;
         q_err[wr_ptr]  <= imem_rsp_err;
      end
   end

   no_overflow: assert property (
      @(posedge clk) disable iff (rst)
      !(push && (count == CW'(DEPTH)))
   );

endmodule
